// File: rtl/matu_pkg.sv
// -----------------------------------------------------------------------------
// matu_pkg
// Shared definitions for the matrix-unit result path.
//   ob_state_t  : output buffer control states (S_EMPTY, S_FILL, S_DRAIN)
//   ptr_width() : width of a pointer able to hold 0..count (clog2 + 1 bit)
// -----------------------------------------------------------------------------
package matu_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } ob_state_t;

    // One spare bit over clog2 keeps a pointer wide enough for its full count,
    // and stays at least 1 bit wide when the count is 1.
    function automatic int ptr_width(input int count);
        return $clog2(count) + 1;
    endfunction

endpackage

// File: rtl/output_buffer.sv
// -----------------------------------------------------------------------------
// output_buffer
// Captures one tile of SA_ROWS result rows from the systolic array controller,
// then drains it element by element (row-major, row 0 element 0 first) over a
// valid/ready stream.
//
// Ports
//   i_clk       : clock, everything on the rising edge
//   i_rst       : synchronous active-high reset
//   i_data_in   : row write strobe, one row per high cycle
//   i_data      : row payload, element c at [c*DATA_W +: DATA_W]
//   o_empty     : registered, high only while idle and ready for a new tile
//   o_valid     : o_data carries a beat
//   i_ready     : downstream accepts the beat
//   o_data      : current element, zero while o_valid is low
//   o_last      : final beat of the tile
//   o_overflow  : sticky, a row write arrived while draining (write dropped)
// -----------------------------------------------------------------------------
module output_buffer
    import matu_pkg::*;
#(
    parameter int SA_ROWS = 3,
    parameter int SA_COLS = 1,
    parameter int DATA_W  = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_data_in,
    input  logic [SA_COLS*DATA_W-1:0]   i_data,
    output logic                        o_empty,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_last,
    output logic                        o_overflow
);

    localparam int ROW_PW = ptr_width(SA_ROWS);
    localparam int COL_PW = ptr_width(SA_COLS);
    localparam int ROW_W  = SA_COLS * DATA_W;

    localparam logic [ROW_PW-1:0] LAST_ROW = ROW_PW'(SA_ROWS - 1);
    localparam logic [COL_PW-1:0] LAST_COL = COL_PW'(SA_COLS - 1);

    // ---------------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------------
    ob_state_t          state_reg,    state_next;
    logic [ROW_PW-1:0]  wr_ptr_reg,   wr_ptr_next;
    logic [ROW_PW-1:0]  rd_row_reg,   rd_row_next;
    logic [COL_PW-1:0]  rd_col_reg,   rd_col_next;
    logic               empty_reg,    empty_next;
    logic               overflow_reg, overflow_next;
    logic               wr_en;

    // ---------------------------------------------------------------------
    // Storage: one register per row, payload kept verbatim
    // ---------------------------------------------------------------------
    logic [ROW_W-1:0]   row_reg [SA_ROWS];
    logic [SA_ROWS-1:0] row_we;
    logic [ROW_W-1:0]   cur_row;
    logic [DATA_W-1:0]  cur_elems [SA_COLS];
    logic [DATA_W-1:0]  cur_elem;
    logic               drain_active;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= S_EMPTY;
            wr_ptr_reg   <= '0;
            rd_row_reg   <= '0;
            rd_col_reg   <= '0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_row_reg   <= rd_row_next;
            rd_col_reg   <= rd_col_next;
            empty_reg    <= empty_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_row_next   = rd_row_reg;
        rd_col_next   = rd_col_reg;
        overflow_next = overflow_reg;
        wr_en         = 1'b0;

        case (state_reg)
            S_EMPTY: begin
                if (i_data_in) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = ROW_PW'(1);
                    // A single-row tile is complete after its first write.
                    state_next  = (SA_ROWS == 1) ? S_DRAIN : S_FILL;
                end
            end

            S_FILL: begin
                // Idle cycles simply hold state and the write pointer.
                if (i_data_in) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr_reg + ROW_PW'(1);
                    if (wr_ptr_reg == LAST_ROW) begin
                        state_next = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // Writes here are dropped; only the sticky flag records them.
                if (i_data_in) begin
                    overflow_next = 1'b1;
                end
                // o_valid is constantly high in this state, so i_ready alone
                // completes the handshake.
                if (i_ready) begin
                    if (rd_col_reg == LAST_COL) begin
                        rd_col_next = '0;
                        if (rd_row_reg == LAST_ROW) begin
                            state_next  = S_EMPTY;
                            rd_row_next = '0;
                            wr_ptr_next = '0;
                        end else begin
                            rd_row_next = rd_row_reg + ROW_PW'(1);
                        end
                    end else begin
                        rd_col_next = rd_col_reg + COL_PW'(1);
                    end
                end
            end

            default: begin
                state_next  = S_EMPTY;
                wr_ptr_next = '0;
                rd_row_next = '0;
                rd_col_next = '0;
            end
        endcase

        // o_empty comes straight from a flop, so it has no path from i_data_in.
        empty_next = (state_next == S_EMPTY);
    end

    // Per-row write enables decoded from the write pointer.
    for (genvar gi = 0; gi < SA_ROWS; gi++) begin : g_row_we
        assign row_we[gi] = wr_en && (wr_ptr_reg == ROW_PW'(gi));
    end

    // Storage is not reset: a discarded tile is simply overwritten later.
    always_ff @(posedge i_clk) begin
        for (int r = 0; r < SA_ROWS; r++) begin
            if (row_we[r]) begin
                row_reg[r] <= i_data;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read path: select row, then element within the row
    // ---------------------------------------------------------------------
    always_comb begin
        cur_row = '0;
        for (int r = 0; r < SA_ROWS; r++) begin
            if (rd_row_reg == ROW_PW'(r)) begin
                cur_row = row_reg[r];
            end
        end
    end

    for (genvar gi = 0; gi < SA_COLS; gi++) begin : g_col_split
        assign cur_elems[gi] = cur_row[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        cur_elem = '0;
        for (int c = 0; c < SA_COLS; c++) begin
            if (rd_col_reg == COL_PW'(c)) begin
                cur_elem = cur_elems[c];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: all derived from registered state, so they hold during stalls
    // ---------------------------------------------------------------------
    assign drain_active = (state_reg == S_DRAIN);
    assign o_empty      = empty_reg;
    assign o_valid      = drain_active;
    assign o_data       = drain_active ? cur_elem : '0;
    assign o_last       = drain_active && (rd_row_reg == LAST_ROW) && (rd_col_reg == LAST_COL);
    assign o_overflow   = overflow_reg;

endmodule
